eth_tx_scheduler: RTL and testbench

Per-row UDP packet scheduler in the `clk_eth` domain, placed between the pixel-packing line FIFO and the UDP/RGMII transmitter inside `ethernet`. It waits until one full image row of packed Sobel bits (IMAGE_WIDTH/8 bytes) is buffered, then starts one UDP packet of DATA_LENGTH bytes: a 2-byte row header followed by the row payload drained from the FIFO. It enforces an inter-packet gap, counts rows, and signals frame completion.

---
 rtl/eth_tx_scheduler_pkg.sv | 16 +
 rtl/eth_tx_scheduler_if.sv | 39 +++
 rtl/eth_tx_scheduler.sv | 153 +++++++++++++++
 tb/tb_eth_tx_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_scheduler_pkg.sv
// Shared types and header field widths for the per-row UDP packet scheduler.
package eth_pkg;

  localparam int unsigned FRAME_ID_W = 4;
  localparam int unsigned ROW_W      = 12;

  typedef enum logic [2:0] {
    StIdle,
    StWaitData,
    StStart,
    StSend,
    StWaitDone,
    StGap
  } state_e;

endpackage

// File: rtl/eth_tx_scheduler_if.sv
// Line-FIFO read side plus UDP transmitter handshake, as seen by the scheduler.
interface eth_tx_scheduler_if #(
  parameter int unsigned USAGE_WIDTH = 11
);

  logic [USAGE_WIDTH-1:0] fifo_read_usage;
  logic [7:0]             fifo_dout;
  logic                   fifo_rd_en;
  logic                   tx_start;
  logic [15:0]            tx_byte_num;
  logic                   tx_req;
  logic [7:0]             tx_data;
  logic                   tx_done;

  // Scheduler side.
  modport master (
    input  fifo_read_usage,
    input  fifo_dout,
    input  tx_req,
    input  tx_done,
    output fifo_rd_en,
    output tx_start,
    output tx_byte_num,
    output tx_data
  );

  // FIFO / transmitter side.
  modport slave (
    output fifo_read_usage,
    output fifo_dout,
    output tx_req,
    output tx_done,
    input  fifo_rd_en,
    input  tx_start,
    input  tx_byte_num,
    input  tx_data
  );

endinterface

// File: rtl/eth_tx_scheduler.sv
// Per-row UDP packet scheduler: waits for one buffered image row, sends a
// 2-byte row header followed by the row payload, enforces the inter-packet gap.
module eth_tx_scheduler
  import eth_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = 1280,
  parameter int unsigned IMAGE_HEIGHT = 720,
  parameter int unsigned DATA_LENGTH  = 162,
  parameter int unsigned IFG_CYCLES   = 12,
  parameter int unsigned USAGE_WIDTH  = 11
) (
  input  logic                clk_eth,
  input  logic                rst,
  input  logic                frame_start,
  output logic                frame_done,
  output logic                proto_err,
  eth_tx_scheduler_if.master  bus
);

  localparam int unsigned ROW_BYTES = IMAGE_WIDTH / 8;

  if (DATA_LENGTH != ROW_BYTES + 2) begin : g_len_check
    $error("eth_tx_scheduler: DATA_LENGTH must equal IMAGE_WIDTH/8 + 2");
  end
  if (IMAGE_WIDTH % 8 != 0) begin : g_width_check
    $error("eth_tx_scheduler: IMAGE_WIDTH must be a multiple of 8");
  end

  state_e                state_q;
  logic [ROW_W-1:0]      row_cnt_q;
  logic [FRAME_ID_W-1:0] frame_id_q;
  logic [15:0]           byte_cnt_q;
  logic [15:0]           gap_cnt_q;
  logic                  pending_q;
  logic                  tx_start_q;
  logic [15:0]           tx_byte_num_q;
  logic                  frame_done_q;
  logic                  proto_err_q;
  logic [7:0]            hdr_q;
  logic                  sel_q;      // 1: tx_data comes from the FIFO
  logic [USAGE_WIDTH-1:0] usage;
  logic                  row_ready;
  logic                  last_req;

  assign usage     = bus.fifo_read_usage;
  assign row_ready = (usage >= USAGE_WIDTH'(ROW_BYTES));
  assign last_req  = (byte_cnt_q == 16'(DATA_LENGTH - 1));

  // Payload bytes are read straight through; tx_done aborts suppress the read.
  always_comb begin
    bus.fifo_rd_en = (state_q == StSend) && bus.tx_req && !bus.tx_done &&
                     (byte_cnt_q >= 16'd2);
  end

  assign bus.tx_data     = sel_q ? bus.fifo_dout : hdr_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_byte_num = tx_byte_num_q;
  assign frame_done      = frame_done_q;
  assign proto_err       = proto_err_q;

  // Scheduler FSM with row/frame/byte/gap counters and registered outputs.
  always_ff @(posedge clk_eth or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      row_cnt_q     <= '0;
      frame_id_q    <= '0;
      byte_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      pending_q     <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_byte_num_q <= '0;
      frame_done_q  <= 1'b0;
      proto_err_q   <= 1'b0;
      hdr_q         <= '0;
      sel_q         <= 1'b0;
    end else begin
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (frame_start && (state_q != StIdle)) pending_q <= 1'b1;
      if (bus.tx_req && (state_q != StSend)) proto_err_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            row_cnt_q  <= '0;
            frame_id_q <= frame_id_q + FRAME_ID_W'(1);
            state_q    <= StWaitData;
          end
        end
        StWaitData: begin
          if (row_ready) begin
            tx_start_q    <= 1'b1;
            tx_byte_num_q <= 16'(DATA_LENGTH);
            byte_cnt_q    <= '0;
            state_q       <= StStart;
          end
        end
        StStart: begin
          // Usage can only fall by reads we issue; a drop here is a glitch.
          if (!row_ready) proto_err_q <= 1'b1;
          state_q <= StSend;
        end
        StSend: begin
          if (bus.tx_done) begin
            proto_err_q <= 1'b1;
            gap_cnt_q   <= '0;
            state_q     <= StGap;
          end else if (bus.tx_req) begin
            byte_cnt_q <= byte_cnt_q + 16'd1;
            if (byte_cnt_q == 16'd0) begin
              hdr_q <= {frame_id_q, row_cnt_q[ROW_W-1:8]};
              sel_q <= 1'b0;
            end else if (byte_cnt_q == 16'd1) begin
              hdr_q <= row_cnt_q[7:0];
              sel_q <= 1'b0;
            end else begin
              sel_q <= 1'b1;
            end
            if (last_req) state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (bus.tx_done) begin
            row_cnt_q <= row_cnt_q + ROW_W'(1);
            gap_cnt_q <= '0;
            state_q   <= StGap;
          end
        end
        StGap: begin
          if (gap_cnt_q == 16'(IFG_CYCLES - 1)) begin
            if (pending_q || frame_start) begin
              // A frame restart abandons the partial frame silently.
              pending_q  <= 1'b0;
              row_cnt_q  <= '0;
              frame_id_q <= frame_id_q + FRAME_ID_W'(1);
              state_q    <= StWaitData;
            end else if (row_cnt_q == ROW_W'(IMAGE_HEIGHT)) begin
              frame_done_q <= 1'b1;
              row_cnt_q    <= '0;
              state_q      <= StIdle;
            end else begin
              state_q <= StWaitData;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Directed frame sequences with randomized payload and tx_req spacing, checked
// against a row/frame-level model of the packet stream.
module tb_eth_tx_scheduler;

  localparam int IW  = 1280;
  localparam int IH  = 3;
  localparam int DL  = 162;
  localparam int IFG = 12;
  localparam int UW  = 11;
  localparam int RB  = IW / 8;

  logic clk_eth = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic frame_done;
  logic proto_err;

  eth_tx_scheduler_if #(.USAGE_WIDTH(UW)) bus ();

  eth_tx_scheduler #(
    .IMAGE_WIDTH (IW),
    .IMAGE_HEIGHT(IH),
    .DATA_LENGTH (DL),
    .IFG_CYCLES  (IFG),
    .USAGE_WIDTH (UW)
  ) dut (
    .clk_eth    (clk_eth),
    .rst        (rst),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .proto_err  (proto_err),
    .bus        (bus)
  );

  initial forever #4 clk_eth = ~clk_eth;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_rd = 0;
  int n_bad_rd = 0;
  int n_start = 0;
  int n_fd = 0;
  int done_cyc = -1;

  logic [7:0] fifo_q[$];
  logic [7:0] ref_q[$];

  logic [3:0]  exp_fid = 4'd0;
  logic [11:0] exp_row = 12'd0;
  int          exp_fd = 0;
  bit          pend = 1'b0;

  // Standard (non-FWFT) FIFO model; reset by the same rst as the DUT.
  always @(posedge clk_eth) begin
    cyc <= cyc + 1;
    if (rst) begin
      fifo_q.delete();
      bus.fifo_dout       <= 8'h00;
      bus.fifo_read_usage <= '0;
    end else begin
      if (bus.fifo_rd_en) begin
        n_rd <= n_rd + 1;
        if (!bus.tx_req) n_bad_rd <= n_bad_rd + 1;
        if (fifo_q.size() > 0) bus.fifo_dout <= fifo_q.pop_front();
        else bus.fifo_dout <= 8'hxx;
      end
      bus.fifo_read_usage <= UW'(fifo_q.size());
    end
  end

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk_eth) begin
    if (!rst) begin
      if (bus.tx_start) n_start <= n_start + 1;
      if (frame_done) n_fd <= n_fd + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    ref_q.push_back(b);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push(8'($urandom));
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(negedge clk_eth);
    frame_start = 1'b0;
  endtask

  task automatic wait_start();
    int w;
    w = 0;
    while (!bus.tx_start && w < 400) begin
      @(negedge clk_eth);
      w++;
    end
    check("tx_start_seen", bus.tx_start, 1);
  endtask

  // One packet: n_req requests (DL = complete, fewer = aborted by tx_done),
  // optional frame_start at request index fs_at, push_after bytes queued
  // before tx_done.
  task automatic do_packet(input int n_req, input int max_gap, input int fs_at,
                           input int push_after);
    logic [7:0] exp_b[$];
    int  sent;
    int  k;
    bit  prev;
    bit  fs_done;
    wait_start();
    check("tx_byte_num", bus.tx_byte_num, DL);
    if (done_cyc >= 0) check("ifg_min", 32'((cyc - done_cyc) >= IFG + 2), 1);
    exp_b.push_back({exp_fid, exp_row[11:8]});
    exp_b.push_back(exp_row[7:0]);
    for (int i = 2; i < n_req; i++) exp_b.push_back(ref_q.pop_front());
    sent = 0;
    k = 0;
    prev = 1'b0;
    fs_done = 1'b0;
    while (sent < n_req || prev) begin
      @(negedge clk_eth);
      if (prev) begin
        check("tx_data", bus.tx_data, exp_b[k]);
        k++;
      end
      frame_start = (fs_at == sent) && !fs_done;
      if (frame_start) fs_done = 1'b1;
      if (sent < n_req && $urandom_range(0, max_gap) == 0) begin
        bus.tx_req = 1'b1;
        sent++;
        prev = 1'b1;
      end else begin
        bus.tx_req = 1'b0;
        prev = 1'b0;
      end
    end
    frame_start = 1'b0;
    bus.tx_req = 1'b0;
    push_rand(push_after);
    repeat ($urandom_range(1, 4)) @(negedge clk_eth);
    bus.tx_done = 1'b1;
    done_cyc = cyc;
    @(negedge clk_eth);
    bus.tx_done = 1'b0;
    if (fs_at >= 0) pend = 1'b1;
    if (pend) begin
      exp_fid = exp_fid + 4'd1;
      exp_row = 12'd0;
      pend = 1'b0;
    end else if (n_req == DL) begin
      exp_row = exp_row + 12'd1;
      if (exp_row == 12'(IH)) begin
        exp_row = 12'd0;
        exp_fd++;
      end
    end
  endtask

  task automatic wait_fd();
    int w;
    w = 0;
    while (!frame_done && w < 40) begin
      @(negedge clk_eth);
      w++;
    end
    check("frame_done_seen", frame_done, 1);
    check("frame_done_gap", 32'((cyc - done_cyc) >= IFG + 1 && (cyc - done_cyc) <= IFG + 2), 1);
    @(negedge clk_eth);
    check("frame_done_count", n_fd, exp_fd);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_start"}, bus.tx_start, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_proto_err"}, proto_err, 0);
    check({tag, "_fifo_rd_en"}, bus.fifo_rd_en, 0);
    check({tag, "_tx_byte_num"}, bus.tx_byte_num, 0);
    check({tag, "_tx_data"}, bus.tx_data, 0);
  endtask

  initial begin
    int start_snap;
    int rd_snap;
    int w;
    bus.tx_req  = 1'b0;
    bus.tx_done = 1'b0;
    repeat (3) @(negedge clk_eth);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk_eth);

    // Frame 1: usage threshold, then three rows.
    pulse_fs();
    exp_fid = 4'd1;
    exp_row = 12'd0;
    for (int i = 0; i < RB - 1; i++) push(8'(i));
    repeat (20) @(negedge clk_eth);
    check("no_start_at_159", n_start, 0);
    push(8'(RB - 1));
    w = 0;
    while (bus.fifo_read_usage != UW'(RB) && w < 5) begin
      @(negedge clk_eth);
      w++;
    end
    check("usage_reached", bus.fifo_read_usage, RB);
    check("start_not_same_cycle", bus.tx_start, 0);
    @(negedge clk_eth);
    check("start_next_cycle", bus.tx_start, 1);
    do_packet(DL, 0, -1, RB);
    do_packet(DL, 3, -1, RB);
    do_packet(DL, 1, -1, 0);
    wait_fd();
    check("frame1_starts", n_start, 3);
    check("frame1_reads", n_rd, 3 * RB);
    check("frame1_proto_err", proto_err, 0);

    // Frame 2 restarted mid-row, then abort and resend inside frame 3.
    pulse_fs();
    exp_fid = exp_fid + 4'd1;
    exp_row = 12'd0;
    push_rand(RB);
    do_packet(DL, 0, -1, RB);
    do_packet(DL, 2, 80, RB);
    do_packet(DL, 1, -1, RB);
    check("partial_no_frame_done", n_fd, 1);
    check("pre_abort_proto_err", proto_err, 0);
    do_packet(50, 0, -1, RB);
    check("abort_proto_err", proto_err, 1);
    do_packet(DL, 1, -1, RB);
    check("proto_err_sticky", proto_err, 1);
    do_packet(DL, 0, -1, 0);
    wait_fd();
    check("no_stray_reads", n_bad_rd, 0);

    // Reset in the middle of a packet.
    pulse_fs();
    push_rand(RB);
    wait_start();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_eth);
      bus.tx_req = 1'b1;
    end
    @(negedge clk_eth);
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_rst");
    bus.tx_req = 1'b0;
    repeat (2) @(negedge clk_eth);
    rst = 1'b0;
    ref_q.delete();
    exp_fid = 4'd0;
    exp_row = 12'd0;
    done_cyc = -1;
    push_rand(RB);
    start_snap = n_start;
    rd_snap = n_rd;
    repeat (40) @(negedge clk_eth);
    check("post_rst_no_start", n_start, start_snap);
    check("post_rst_no_reads", n_rd, rd_snap);
    pulse_fs();
    exp_fid = 4'd1;
    do_packet(DL, 1, -1, 0);
    check("post_rst_one_start", n_start, start_snap + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
